// File: rtl/tile_spawner.sv
// New-tile spawner for the 4x4 board: counts empty cells, reduces an LFSR draw to
// a choice among them, then writes one tile. Optional macro SPAWN_FOUR_EN adds "4" tiles.
module tile_spawner #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int          TILE_W    = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  output logic [3:0]        rd_addr,
  input  logic [TILE_W-1:0] rd_data,
  output logic              wr_en,
  output logic [3:0]        wr_addr,
  output logic [TILE_W-1:0] wr_data,
  output logic              busy,
  output logic              done,
  output logic              full
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_COUNT,
    S_REDUCE,
    S_LOCATE,
    S_WRITE,
    S_DONE
  } state_e;

  localparam logic [TILE_W-1:0] TILE_TWO  = TILE_W'(1);
  localparam logic [TILE_W-1:0] TILE_FOUR = TILE_W'(2);

  state_e            state_q, state_d;
  logic [15:0]       lfsr_q, lfsr_d;
  logic [3:0]        rd_addr_q, rd_addr_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [3:0]        r_q, r_d;
  logic [4:0]        e_q, e_d;
  logic [3:0]        wr_addr_q, wr_addr_d;
  logic [TILE_W-1:0] wr_data_q, wr_data_d;
  logic              full_q, full_d;
  logic [TILE_W-1:0] new_tile;
  logic              rd_empty;
  logic [4:0]        cnt_sum;

`ifdef SPAWN_FOUR_EN
  logic four_sel_q, four_sel_d;
  assign new_tile = four_sel_q ? TILE_FOUR : TILE_TWO;
`else
  assign new_tile = TILE_TWO;
`endif

  assign rd_empty = (rd_data == '0);
  assign cnt_sum  = cnt_q + {4'b0, rd_empty};

  // NOTE: every _d gets a default first so no path through the case leaves a latch.
  always_comb begin
    state_d   = state_q;
    lfsr_d    = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    rd_addr_d = rd_addr_q;
    cnt_d     = cnt_q;
    r_d       = r_q;
    e_d       = e_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    full_d    = full_q;
`ifdef SPAWN_FOUR_EN
    four_sel_d = four_sel_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_COUNT;
          rd_addr_d = 4'd0;
          cnt_d     = 5'd0;
          full_d    = 1'b0;
          r_d       = lfsr_q[3:0];
`ifdef SPAWN_FOUR_EN
          four_sel_d = (lfsr_q[15:12] == 4'h0);
`endif
        end
      end

      S_COUNT: begin
        cnt_d     = cnt_sum;
        rd_addr_d = rd_addr_q + 4'd1;
        if (rd_addr_q == 4'd15) begin
          rd_addr_d = 4'd0;
          if (cnt_sum == 5'd0) begin
            state_d = S_DONE;
            full_d  = 1'b1;
          end else begin
            state_d = S_REDUCE;
          end
        end
      end

      // Repeated subtraction brings the 4-bit draw into 0..cnt-1 without a divider.
      S_REDUCE: begin
        if ({1'b0, r_q} >= cnt_q) begin
          r_d = r_q - cnt_q[3:0];
        end else begin
          state_d   = S_LOCATE;
          rd_addr_d = 4'd0;
          e_d       = 5'd0;
        end
      end

      S_LOCATE: begin
        if (rd_empty && (e_q == {1'b0, r_q})) begin
          state_d   = S_WRITE;
          wr_addr_d = rd_addr_q;
          wr_data_d = new_tile;
          rd_addr_d = 4'd0;
        end else begin
          if (rd_empty) e_d = e_q + 5'd1;
          rd_addr_d = rd_addr_q + 4'd1;
          // Running off the end means the board changed under us: report full, skip the write.
          if (rd_addr_q == 4'd15) begin
            state_d   = S_DONE;
            full_d    = 1'b1;
            rd_addr_d = 4'd0;
          end
        end
      end

      S_WRITE: state_d = S_DONE;

      S_DONE: state_d = S_IDLE;

      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      lfsr_q    <= LFSR_SEED;
      rd_addr_q <= 4'd0;
      cnt_q     <= 5'd0;
      r_q       <= 4'd0;
      e_q       <= 5'd0;
      wr_addr_q <= 4'd0;
      wr_data_q <= '0;
      full_q    <= 1'b0;
`ifdef SPAWN_FOUR_EN
      four_sel_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      lfsr_q    <= lfsr_d;
      rd_addr_q <= rd_addr_d;
      cnt_q     <= cnt_d;
      r_q       <= r_d;
      e_q       <= e_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      full_q    <= full_d;
`ifdef SPAWN_FOUR_EN
      four_sel_q <= four_sel_d;
`endif
    end
  end

  assign rd_addr = rd_addr_q;
  assign wr_addr = wr_addr_q;
  assign wr_data = wr_data_q;
  assign wr_en   = (state_q == S_WRITE);
  assign busy    = (state_q != S_IDLE);
  assign done    = (state_q == S_DONE);
  assign full    = full_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: fixed board table, hand-written corner
// sequences, and random boards checked against an arithmetic reference model.
module tb_tile_spawner;

  localparam logic [15:0] SEED = 16'hACE1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [3:0] rd_addr;
  logic [3:0] rd_data;
  logic       wr_en;
  logic [3:0] wr_addr;
  logic [3:0] wr_data;
  logic       busy;
  logic       done;
  logic       full;

  logic [3:0]  board [16];
  logic [15:0] lfsr_m;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    int n_wr;
    int wr_addr;
    int wr_data;
    int wr_cyc;
    int done_cyc;
    int full_at_done;
    int full_c1;
    int busy_bad;
    int rd_bad;
    int post_bad;
    int timeout;
  } res_t;

  typedef struct {
    logic [63:0] cells;
    int          exp_full;
    int          exp_addr;
  } vec_t;

  tile_spawner #(.LFSR_SEED(SEED), .TILE_W(4)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (start),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .busy    (busy),
    .done    (done),
    .full    (full)
  );

  always #5 clk = ~clk;

  assign rd_data = board[rd_addr];

  // The polynomial x^16+x^14+x^13+x^11+1, advanced once per clock from the seed.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr_m <= SEED;
    else        lfsr_m <= {lfsr_m[14:0], lfsr_m[15] ^ lfsr_m[13] ^ lfsr_m[12] ^ lfsr_m[10]};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load_board(input logic [63:0] cells);
    for (int i = 0; i < 16; i++) board[i] = cells[4*i +: 4];
  endtask

  // Expected outcome from the board contents and the LFSR value seen at start.
  function automatic res_t model(input logic [15:0] l);
    res_t m;
    int   empties;
    int   draw;
    int   pick;
    int   seen;
    m = '{default: 0};
    m.wr_addr = -1;
    empties = 0;
    for (int i = 0; i < 16; i++) if (board[i] == 4'd0) empties++;
    if (empties == 0) begin
      m.full_at_done = 1;
      m.done_cyc     = 17;
      return m;
    end
    draw = int'(l[3:0]);
    pick = draw % empties;
    seen = 0;
    for (int i = 0; i < 16; i++) begin
      if (board[i] == 4'd0) begin
        if (seen == pick) m.wr_addr = i;
        seen++;
      end
    end
    m.n_wr = 1;
`ifdef SPAWN_FOUR_EN
    m.wr_data = (l[15:12] == 4'h0) ? 2 : 1;
`else
    m.wr_data = 1;
`endif
    m.done_cyc = 16 + (draw / empties + 1) + (m.wr_addr + 1) + 2;
    m.wr_cyc   = m.done_cyc - 1;
    return m;
  endfunction

  // Pulses start, watches until done (bounded), then three quiet cycles.
  task automatic spawn(input int pulse_cyc, input bit pulse_done,
                       output res_t res, output logic [15:0] l_start);
    res = '{default: 0};
    res.wr_addr = -1;
    @(negedge clk);
    l_start = lfsr_m;
    start   = 1'b1;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      start = (c == pulse_cyc);
      if (c == 1) res.full_c1 = full;
      if (!busy) res.busy_bad++;
      if (c <= 16 && rd_addr != 4'(c - 1)) res.rd_bad++;
      if (wr_en) begin
        res.n_wr++;
        res.wr_addr = wr_addr;
        res.wr_data = wr_data;
        res.wr_cyc  = c;
        if (rd_addr != 4'd0) res.rd_bad++;
      end
      if (done) begin
        res.done_cyc     = c;
        res.full_at_done = full;
        if (rd_addr != 4'd0) res.rd_bad++;
        if (pulse_done) start = 1'b1;
        break;
      end
    end
    if (res.done_cyc == 0) res.timeout = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (busy || wr_en || done) res.post_bad++;
    end
  endtask

  task automatic compare(input string tag, input res_t r, input res_t m);
    check({tag, ".timeout"}, r.timeout, 0);
    check({tag, ".n_wr"}, r.n_wr, m.n_wr);
    if (m.n_wr == 1) begin
      check({tag, ".wr_addr"}, r.wr_addr, m.wr_addr);
      check({tag, ".wr_data"}, r.wr_data, m.wr_data);
      check({tag, ".wr_cyc"}, r.wr_cyc, m.wr_cyc);
    end
    check({tag, ".done_cyc"}, r.done_cyc, m.done_cyc);
    check({tag, ".full"}, r.full_at_done, m.full_at_done);
    check({tag, ".full_c1"}, r.full_c1, 0);
    check({tag, ".busy"}, r.busy_bad, 0);
    check({tag, ".rd_addr"}, r.rd_bad, 0);
    check({tag, ".quiet"}, r.post_bad, 0);
  endtask

  initial begin
    vec_t        vecs [6];
    res_t        r;
    res_t        m;
    logic [15:0] l;
    logic [63:0] all3;
    logic [63:0] mixed;
    logic [15:0] covered;
    int          n_two;

    all3  = {16{4'h3}};
    mixed = 64'h1234_5678_9ABC_DEF1;
    vecs[0] = '{all3, 1, -1};
    vecs[1] = '{all3 & ~(64'hF << 36), 0, 9};
    vecs[2] = '{all3 & ~(64'hF << 0), 0, 0};
    vecs[3] = '{all3 & ~(64'hF << 60), 0, 15};
    vecs[4] = '{mixed, 1, -1};
    vecs[5] = '{mixed & ~(64'hF << 24), 0, 6};

    start = 1'b0;
    rst_n = 1'b0;
    load_board(all3);
    repeat (3) @(posedge clk);
    #1;
    check("rst.busy", busy, 0);
    check("rst.done", done, 0);
    check("rst.wr_en", wr_en, 0);
    check("rst.full", full, 0);
    check("rst.rd_addr", rd_addr, 0);
    check("rst.wr_addr", wr_addr, 0);
    check("rst.wr_data", wr_data, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 6; i++) begin
      load_board(vecs[i].cells);
      spawn(0, 1'b0, r, l);
      check($sformatf("vec%0d.full", i), r.full_at_done, vecs[i].exp_full);
      if (vecs[i].exp_addr >= 0) check($sformatf("vec%0d.addr", i), r.wr_addr, vecs[i].exp_addr);
      compare($sformatf("vec%0d", i), r, model(l));
      if (vecs[i].exp_full == 1) check($sformatf("vec%0d.full_hold", i), full, 1);
    end

    // Extra start pulses mid-COUNT and during the DONE cycle must be dropped.
    load_board(all3 & ~(64'hF << 16));
    spawn(5, 1'b1, r, l);
    compare("repulse", r, model(l));
    load_board(64'h0);
    spawn(0, 1'b0, r, l);
    compare("after_repulse", r, model(l));

    // Reset while REDUCE is running (cycle 17 of an empty-board spawn).
    load_board(64'h0);
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 17; c++) begin
      @(negedge clk);
      start = 1'b0;
    end
    check("pre_rst.busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst.busy", busy, 0);
    check("mid_rst.wr_en", wr_en, 0);
    check("mid_rst.done", done, 0);
    check("mid_rst.full", full, 0);
    @(negedge clk);
    rst_n = 1'b1;
    load_board(all3);
    spawn(0, 1'b0, r, l);
    check("post_rst.done_cyc", r.done_cyc, 17);
    compare("post_rst", r, model(l));

    for (int i = 0; i < 40; i++) begin
      for (int j = 0; j < 16; j++)
        board[j] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
      spawn(0, 1'b0, r, l);
      compare($sformatf("rand%0d", i), r, model(l));
    end

    covered = '0;
    n_two   = 0;
    for (int i = 0; i < 1024; i++) begin
      load_board(64'h0);
      spawn(0, 1'b0, r, l);
      compare($sformatf("empty%0d", i), r, model(l));
      if (r.n_wr == 1) covered[r.wr_addr[3:0]] = 1'b1;
      if (r.wr_data == 2) n_two++;
      if (i == 511) check("coverage_all_cells", covered, 16'hFFFF);
    end
`ifdef SPAWN_FOUR_EN
    check("four_seen", (n_two > 0), 1);
`else
    check("four_never", n_two, 0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
